// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/response bundle for the alu_seq sequential ALU.
//   Request : in_valid, in_ready, op_code[7:0], data_A, data_B
//   Response: out_valid, out_ready, result, result_hi, status[3:0] {V,C,N,Z}, err
// master: requester/consumer side; slave: the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       op_code;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       status;
  logic             err;

  modport master (
    output in_valid, op_code, data_A, data_B, out_ready,
    input  in_ready, out_valid, result, result_hi, status, err
  );

  modport slave (
    input  in_valid, op_code, data_A, data_B, out_ready,
    output in_ready, out_valid, result, result_hi, status, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//   SUM/SUB/INC/DEC and illegal opcodes complete in one cycle; MULT (radix-2
//   shift-add) and DIV (unsigned restoring) take WIDTH iterations.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave (request, operands, result, result_hi, status {V,C,N,Z}, err)
// Configuration macro: ALU_SEQ_MULDIV_EN -- when defined, MULT/DIV are
//   implemented; otherwise they are treated as illegal opcodes.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam logic [7:0] OP_SUM  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_INC  = 8'h03;
  localparam logic [7:0] OP_DEC  = 8'h04;
`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [7:0] OP_MULT = 8'h05;
  localparam logic [7:0] OP_DIV  = 8'h06;
  localparam int         CNT_W   = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic accept;
  logic last_step;

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   wide;
  logic             is_sub;
  logic             is_legal;
  logic             start_mul;
  logic             start_div;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    opnd_b    = bus.data_B;
    is_sub    = 1'b0;
    is_legal  = 1'b1;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (bus.op_code)
      OP_SUM: ;
      OP_SUB: is_sub = 1'b1;
      OP_INC: opnd_b = WIDTH'(1);
      OP_DEC: begin
        opnd_b = WIDTH'(1);
        is_sub = 1'b1;
      end
`ifdef ALU_SEQ_MULDIV_EN
      OP_MULT: start_mul = 1'b1;
      OP_DIV:  start_div = 1'b1;
`endif
      default: is_legal = 1'b0;
    endcase

    if (is_sub) wide = {1'b0, bus.data_A} - {1'b0, opnd_b};
    else        wide = {1'b0, bus.data_A} + {1'b0, opnd_b};
    alu_res = wide[WIDTH-1:0];
    // Bit WIDTH is carry-out for adds and borrow for subtracts.
    alu_c   = wide[WIDTH];
    if (is_sub)
      alu_v = (bus.data_A[WIDTH-1] != opnd_b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.data_A[WIDTH-1]);
    else
      alu_v = (bus.data_A[WIDTH-1] == opnd_b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.data_A[WIDTH-1]);
  end

`ifdef ALU_SEQ_MULDIV_EN
  // Iterative engine. acc_hi:acc_lo is the product register for MULT
  // (multiplier shifts out of acc_lo) and remainder:quotient for DIV
  // (dividend shifts out of acc_lo, quotient bits shift in).
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (state == MUL) begin
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_reg} : '0);
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_reg};
      // A zero divisor always "fits": quotient saturates to all-ones and
      // the remainder accumulates the dividend unchanged.
      if (div_shift >= {1'b0, opnd_reg}) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_reg <= '0;
      cnt      <= '0;
    end else if (accept) begin
      acc_hi   <= '0;
      acc_lo   <= bus.data_A;
      opnd_reg <= bus.data_B;
      cnt      <= '0;
    end else if (state == MUL || state == DIV) begin
      acc_hi   <= step_hi;
      acc_lo   <= step_lo;
      cnt      <= cnt + CNT_W'(1);
    end
  end
`else
  assign last_step = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (start_mul)      state_next = MUL;
          else if (start_div) state_next = DIV;
          else                state_next = DONE;
        end
      end
      MUL, DIV: if (last_step) state_next = DONE;
      DONE:     if (bus.out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Result registers load only when DONE is entered, so they hold steady
  // for the whole DONE period and retain the last values elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.status    <= '0;
      bus.err       <= 1'b0;
    end else if (accept && !start_mul && !start_div) begin
      bus.result_hi <= '0;
      if (is_legal) begin
        bus.result <= alu_res;
        bus.status <= {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
        bus.err    <= 1'b0;
      end else begin
        bus.result <= '0;
        bus.status <= 4'b0001;
        bus.err    <= 1'b1;
      end
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if ((state == MUL || state == DIV) && last_step) begin
      bus.result    <= step_lo;
      bus.result_hi <= step_hi;
      if (state == MUL) begin
        bus.status <= {(step_hi != '0), (step_hi != '0), step_lo[WIDTH-1], (step_lo == '0)};
        bus.err    <= 1'b0;
      end else begin
        bus.status <= {(opnd_reg == '0), 1'b0, step_lo[WIDTH-1], (step_lo == '0)};
        bus.err    <= (opnd_reg == '0);
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- scoreboard bench for alu_seq (WIDTH=8). Stimulus pushes the
// reference result into a queue; an independent monitor pops on out_valid.
module tb_alu_seq;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [3:0]   status;
    logic         err;
    int unsigned  lat;
    int unsigned  acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_vec;
  int          n_bad;
  bit          mon_active;
  bit          stuck;
  exp_t        sb[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode's definition.
  function automatic exp_t model(input logic [7:0] op, input longint a_in, input longint b_in);
    exp_t   e;
    longint m    = (longint'(1) << W) - 1;
    longint half = longint'(1) << (W - 1);
    longint a    = a_in;
    longint b    = b_in;
    longint r    = 0;
    longint sa, sb_s, sr, p;
    bit     c = 0, v = 0, legal = 1;
    e.hi  = '0;
    e.err = 1'b0;
    e.lat = 1;
    if (op == 8'h03 || op == 8'h04) b = 1;
    sa   = (a >= half) ? a - (m + 1) : a;
    sb_s = (b >= half) ? b - (m + 1) : b;
    case (op)
      8'h01, 8'h03: begin
        r  = (a + b) & m;
        c  = (a + b) > m;
        sr = sa + sb_s;
        v  = (sr >= half) || (sr < -half);
      end
      8'h02, 8'h04: begin
        r  = (a - b) & m;
        c  = a < b;
        sr = sa - sb_s;
        v  = (sr >= half) || (sr < -half);
      end
`ifdef ALU_SEQ_MULDIV_EN
      8'h05: begin
        p     = a * b;
        r     = p & m;
        e.hi  = W'(p >> W);
        c     = (p >> W) != 0;
        v     = c;
        e.lat = W + 1;
      end
      8'h06: begin
        e.lat = W + 1;
        if (b == 0) begin
          r     = m;
          e.hi  = W'(a);
          e.err = 1'b1;
          v     = 1;
        end else begin
          r    = a / b;
          e.hi = W'(a % b);
        end
      end
`endif
      default: legal = 0;
    endcase
    if (legal) begin
      e.result = W'(r);
      e.status = {v, c, (r >= half), (r == 0)};
    end else begin
      e.result = '0;
      e.hi     = '0;
      e.status = 4'b0001;
      e.err    = 1'b1;
    end
    return e;
  endfunction

  // Issue one request; while the ALU is busy the inputs are scrambled to
  // show they are ignored outside IDLE.
  task automatic send(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned waited = 0;
    if (stuck) return;
    @(negedge clk);
    while (!bus.in_ready && waited < 300) begin
      bus.in_valid = 1'b1;
      bus.op_code  = 8'($urandom);
      bus.data_A   = W'($urandom);
      bus.data_B   = W'($urandom);
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      stuck = 1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.op_code  = op;
    bus.data_A   = a;
    bus.data_B   = b;
    e = model(op, a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      3:       return (W'(1) << (W - 1)) - W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rnd_op();
    int unsigned k = $urandom_range(0, 13);
    if (k < 12) return 8'(k % 6 + 1);
    if (k == 12) return 8'h00;
    return 8'($urandom_range(7, 255));
  endfunction

  // Monitor: pops on the first DONE cycle, then checks stability while
  // out_ready is held low.
  initial begin : monitor
    exp_t        cur;
    int unsigned hold_left = 0;
    int unsigned txn = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (!mon_active) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            cur = sb.pop_front();
            mon_active = 1;
            chk("latency", cyc - cur.acc_cyc, cur.lat);
            chk("result", bus.result, cur.result);
            chk("result_hi", bus.result_hi, cur.hi);
            chk("status", bus.status, cur.status);
            chk("err", bus.err, cur.err);
            hold_left = (txn < 6 || $urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 1);
            txn++;
          end
        end else begin
          chk("stable_result", bus.result, cur.result);
          chk("stable_result_hi", bus.result_hi, cur.hi);
          chk("stable_status", bus.status, cur.status);
          chk("stable_err", bus.err, cur.err);
          chk("in_ready_in_done", bus.in_ready, 0);
        end
        if (mon_active) begin
          if (hold_left > 0) begin
            bus.out_ready = 1'b0;
            hold_left--;
          end else begin
            bus.out_ready = 1'b1;
            mon_active = 0;
          end
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : stimulus
    int unsigned n;
    n_vec = 0;
    n_bad = 0;
    mon_active = 0;
    stuck = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_code  = '0;
    bus.data_A   = '0;
    bus.data_B   = '0;

    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_hi", bus.result_hi, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1);

    send(8'h01, 8'h7F, 8'h01);
    send(8'h02, 8'h00, 8'h01);
    send(8'h04, 8'h00, 8'h5A);
    send(8'h03, 8'hFF, 8'h33);
    send(8'h01, 8'hFF, 8'h01);
    send(8'h05, 8'hFF, 8'hFF);
    send(8'h06, 8'd100, 8'd7);
    send(8'h06, 8'd5, 8'd0);
    send(8'h00, 8'h12, 8'h34);
    send(8'h02, 8'h80, 8'h01);

    // Asynchronous reset in the middle of a divide.
    send(8'h06, 8'd200, 8'd9);
    if (!stuck) begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_result", bus.result, 0);
      chk("async_rst_result_hi", bus.result_hi, 0);
      chk("async_rst_status", bus.status, 0);
      chk("async_rst_err", bus.err, 0);
      sb.delete();
      mon_active = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
        @(negedge clk);
        if (i == 0) chk("in_ready_after_mid_reset", bus.in_ready, 1);
        chk("no_out_valid_after_reset", bus.out_valid, 0);
      end
      send(8'h06, 8'd100, 8'd7);
    end

    for (int i = 0; i < 300 && !stuck; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send(rnd_op(), rnd_val(), rnd_val());
    end

    n = 0;
    while ((sb.size() != 0 || mon_active) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || mon_active) chk("drain_timeout", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
